// File: rtl/game_pkg.sv
// Shared game constants, coordinate type and bullet state encoding.
// Used by the bullet, ship and colour-selector blocks.
package game_pkg;

  localparam int COORD_W  = 19;
  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int SHIP_W   = 100;
  localparam int BULLET_W = 20;
  localparam int BULLET_H = 20;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLYING   = 2'd1,
    COOLDOWN = 2'd2
  } bullet_state_e;

  localparam coord_t PARK_X    = coord_t'(SCREEN_W);
  localparam coord_t PARK_Y    = coord_t'(SCREEN_H);
  localparam coord_t LAUNCH_DX = coord_t'((SHIP_W - BULLET_W) / 2);
  localparam coord_t LAUNCH_DY = coord_t'(BULLET_H);

endpackage

// File: rtl/button_edge_sync.sv
// Two-flop synchroniser plus one-cycle rising-edge pulse for a button.
// A button held through reset must be released before it can fire.
module button_edge_sync (
  input  logic clk,
  input  logic resetn,
  input  logic btn,
  output logic rise
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic [1:0] fill_q, fill_d;
  logic       armed_q, armed_d;

  // fill marks when s2 holds a real post-reset sample; armed once it reads low
  always_comb begin
    s1_d    = btn;
    s2_d    = s1_q;
    prev_d  = s2_q;
    fill_d  = {fill_q[0], 1'b1};
    armed_d = armed_q | (fill_q[1] & ~s2_q);
  end

  // synchroniser, edge and arming registers
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      fill_q  <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      prev_q  <= prev_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
    end
  end

  assign rise = armed_q & s2_q & ~prev_q;

endmodule

// File: rtl/bullet_controller.sv
// Player bullet: launch from ship, climb once per frame, retire on hit/top.
// Parks at (SCREEN_W, SCREEN_H) whenever inactive.
module bullet_controller
  import game_pkg::*;
#(
  parameter int SPEED           = 8,
  parameter int COOLDOWN_FRAMES = 4
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               frame_tick,
  input  logic               fire,
  input  logic               hit,
  input  logic [COORD_W-1:0] ship_x,
  input  logic [COORD_W-1:0] ship_y,
  output logic [COORD_W-1:0] min_x_bullet,
  output logic [COORD_W-1:0] min_y_bullet,
  output logic               bullet_active
);

  localparam int     CNT_W = $clog2(COOLDOWN_FRAMES + 1);
  localparam coord_t STEP  = coord_t'(SPEED);

  bullet_state_e    state_q, state_d;
  coord_t           x_q, x_d;
  coord_t           y_q, y_d;
  logic             active_q, active_d;
  logic             pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fire_rise;

  button_edge_sync u_fire_sync (
    .clk    (clk),
    .resetn (resetn),
    .btn    (fire),
    .rise   (fire_rise)
  );

  // next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    active_d  = active_q;
    pending_d = 1'b0;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        x_d       = PARK_X;
        y_d       = PARK_Y;
        active_d  = 1'b0;
        pending_d = pending_q | fire_rise;
        if (frame_tick && (pending_q || fire_rise)) begin
          x_d       = ship_x + LAUNCH_DX;
          y_d       = (ship_y >= LAUNCH_DY) ? ship_y - LAUNCH_DY : '0;
          active_d  = 1'b1;
          pending_d = 1'b0;
          state_d   = FLYING;
        end
      end
      FLYING: begin
        if (hit || (frame_tick && y_q < STEP)) begin
          x_d      = PARK_X;
          y_d      = PARK_Y;
          active_d = 1'b0;
          cnt_d    = CNT_W'(COOLDOWN_FRAMES);
          state_d  = COOLDOWN;
        end else if (frame_tick) begin
          y_d = y_q - STEP;
        end
      end
      COOLDOWN: begin
        x_d      = PARK_X;
        y_d      = PARK_Y;
        active_d = 1'b0;
        if (frame_tick) begin
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: begin
        x_d      = PARK_X;
        y_d      = PARK_Y;
        active_d = 1'b0;
        cnt_d    = '0;
        state_d  = IDLE;
      end
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= IDLE;
      x_q       <= PARK_X;
      y_q       <= PARK_Y;
      active_q  <= 1'b0;
      pending_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      y_q       <= y_d;
      active_q  <= active_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  assign min_x_bullet  = x_q;
  assign min_y_bullet  = y_q;
  assign bullet_active = active_q;

endmodule

// File: tb/tb_bullet_controller.sv
// Scoreboard bench for bullet_controller.
// Expected output changes are queued; a monitor pops on each change.
module tb_bullet_controller;

  typedef struct packed {
    logic [18:0] x;
    logic [18:0] y;
    logic        a;
  } obs_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        frame_tick = 1'b0;
  logic        fire = 1'b0;
  logic        hit = 1'b0;
  logic [18:0] ship_x = '0;
  logic [18:0] ship_y = '0;
  logic [18:0] min_x_bullet;
  logic [18:0] min_y_bullet;
  logic        bullet_active;

  obs_t exp_q[$];
  obs_t last_obs;
  bit   mon_en = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  bullet_controller dut (
    .clk           (clk),
    .resetn        (resetn),
    .frame_tick    (frame_tick),
    .fire          (fire),
    .hit           (hit),
    .ship_x        (ship_x),
    .ship_y        (ship_y),
    .min_x_bullet  (min_x_bullet),
    .min_y_bullet  (min_y_bullet),
    .bullet_active (bullet_active)
  );

  always #5 clk = ~clk;

  function automatic obs_t mk(int x, int y, bit a);
    obs_t o;
    o.x = 19'(x);
    o.y = 19'(y);
    o.a = a;
    return o;
  endfunction

  function automatic obs_t parked();
    return mk(640, 480, 1'b0);
  endfunction

  task automatic check(string name, obs_t got, obs_t want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got x=%0d y=%0d a=%0b, want x=%0d y=%0d a=%0b",
                  name, got.x, got.y, got.a, want.x, want.y, want.a);
  endtask

  // monitor: each output change must match the next queued expectation
  always @(negedge clk) begin
    obs_t cur;
    cur = {min_x_bullet, min_y_bullet, bullet_active};
    if (mon_en && cur !== last_obs) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_change: got x=%0d y=%0d a=%0b, want no change",
                 cur.x, cur.y, cur.a);
      end else begin
        check("scoreboard", cur, exp_q.pop_front());
      end
      last_obs = cur;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    step();
  endtask

  task automatic press();
    fire = 1'b1;
    repeat (4) step();
    fire = 1'b0;
    repeat (4) step();
  endtask

  task automatic cooldown();
    repeat (4) tick();
  endtask

  task automatic drain(string name);
    repeat (3) step();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL %s: got %0d pending expectations, want 0",
                  name, exp_q.size());
    exp_q.delete();
  endtask

  initial begin
    // reset with fire held
    fire = 1'b1;
    repeat (3) step();
    check("reset_state",
          {min_x_bullet, min_y_bullet, bullet_active}, parked());
    last_obs = parked();
    mon_en = 1'b1;
    resetn = 1'b1;
    repeat (6) step();
    tick();
    tick();
    fire = 1'b0;
    repeat (4) step();
    drain("held_fire_no_launch");

    // launch and climb to the top
    ship_x = 19'd270;
    ship_y = 19'd380;
    press();
    exp_q.push_back(mk(310, 360, 1'b1));
    tick();
    ship_x = 19'd0;
    for (int i = 1; i <= 45; i++) begin
      exp_q.push_back(mk(310, 360 - 8 * i, 1'b1));
      tick();
    end
    exp_q.push_back(parked());
    tick();
    drain("flight_to_top");

    // press during cooldown is ignored
    press();
    repeat (3) tick();
    press();
    tick();
    tick();
    drain("cooldown_no_launch");

    // relaunch after cooldown
    ship_x = 19'd100;
    press();
    exp_q.push_back(mk(140, 360, 1'b1));
    tick();
    exp_q.push_back(parked());
    hit = 1'b1;
    step();
    hit = 1'b0;
    step();
    cooldown();
    drain("relaunch_and_hit");

    // low launch clamps to 0 and retires next tick
    ship_y = 19'd10;
    press();
    exp_q.push_back(mk(140, 0, 1'b1));
    tick();
    exp_q.push_back(parked());
    tick();
    cooldown();
    drain("low_launch");

    // hit beats tick; press in flight is dropped; hit in cooldown ignored
    ship_y = 19'd220;
    press();
    exp_q.push_back(mk(140, 200, 1'b1));
    tick();
    press();
    exp_q.push_back(parked());
    hit = 1'b1;
    frame_tick = 1'b1;
    step();
    hit = 1'b0;
    frame_tick = 1'b0;
    step();
    hit = 1'b1;
    step();
    hit = 1'b0;
    cooldown();
    tick();
    drain("hit_priority");

    // fire edge and tick in the same cycle
    ship_x = 19'd300;
    ship_y = 19'd400;
    fire = 1'b1;
    step();
    step();
    frame_tick = 1'b1;
    exp_q.push_back(mk(340, 380, 1'b1));
    step();
    frame_tick = 1'b0;
    fire = 1'b0;
    repeat (3) step();
    press();
    exp_q.push_back(mk(340, 372, 1'b1));
    tick();
    drain("same_cycle_launch");

    // reset mid-flight
    exp_q.push_back(parked());
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    repeat (6) step();
    tick();
    drain("reset_mid_flight");

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
